// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line request onto a 4-beat 64-bit memory burst.
// One line transfer in flight at a time; all outputs registered except burst_o.
module cacheline_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    localparam int unsigned BEATS = LINE_W / BURST_W;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {StIdle, StRd, StRdDone, StWr, StWrDone} state_e;

    state_e                           state_q;
    logic [CNT_W-1:0]                 cnt_q;
    logic [BEATS-1:0][BURST_W-1:0]    buf_q;
    logic [BEATS-1:0][BURST_W-1:0]    buf_fill;
    logic [ADDR_W-1:0]                line_addr;

    assign line_addr = {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Buffer with the current read beat merged in; also the completed line on the last beat.
    always_comb begin
        buf_fill        = buf_q;
        buf_fill[cnt_q] = burst_i;
    end

    assign burst_o = (state_q == StWr) ? buf_q[cnt_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            buf_q     <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
            line_o    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (read_i) begin
                        address_o <= line_addr;
                        cnt_q     <= '0;
                        read_o    <= 1'b1;
                        state_q   <= StRd;
                    end else if (write_i) begin
                        address_o <= line_addr;
                        cnt_q     <= '0;
                        buf_q     <= line_i;
                        write_o   <= 1'b1;
                        state_q   <= StWr;
                    end
                end
                StRd: begin
                    if (resp_i) begin
                        buf_q <= buf_fill;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            line_o  <= buf_fill;
                            read_o  <= 1'b0;
                            resp_o  <= 1'b1;
                            state_q <= StRdDone;
                        end
                    end
                end
                StWr: begin
                    if (resp_i) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state_q <= StWrDone;
                        end
                    end
                end
                // Returning to idle only after the pulse keeps a lingering request from retriggering.
                StRdDone, StWrDone: begin
                    resp_o  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized bench for cacheline_adaptor: a memory responder with stall patterns and a
// line-level model (beats concatenated ascending, address aligned to 32 bytes).
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [255:0] line_i = '0;
    logic [255:0] line_o;
    logic [31:0]  address_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic         resp_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 1'b0;

    int total = 0;
    int bad = 0;
    logic [255:0] last_line = '0;

    cacheline_adaptor dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_i   (line_i),
        .line_o   (line_o),
        .address_i(address_i),
        .read_i   (read_i),
        .write_i  (write_i),
        .resp_o   (resp_o),
        .burst_i  (burst_i),
        .burst_o  (burst_o),
        .address_o(address_o),
        .read_o   (read_o),
        .write_o  (write_o),
        .resp_i   (resp_i)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [255:0] r256();
        return {r64(), r64(), r64(), r64()};
    endfunction

    // Entered and left at a negedge; request is asserted immediately on entry.
    task automatic do_read(input string name, input logic [31:0] addr, input logic [63:0] b0,
                           input logic [63:0] b1, input logic [63:0] b2, input logic [63:0] b3,
                           input logic [15:0] pat, input int plen, input logic both);
        logic [63:0]  bq[4];
        logic [255:0] exp_line;
        logic [31:0]  exp_addr;
        int           beat;
        int           idx;
        logic         r;
        bq = '{b0, b1, b2, b3};
        exp_line = {b3, b2, b1, b0};
        exp_addr = addr & ~32'h1f;
        read_i = 1'b1; write_i = both; line_i = r256(); address_i = addr; resp_i = 1'b0;
        @(negedge clk);
        total++;
        if ({read_o, write_o, resp_o} !== 3'b100) begin
            bad++; $display("FAIL %s start r/w/resp got %b want 100", name, {read_o, write_o, resp_o});
        end
        total++;
        if (address_o !== exp_addr) begin
            bad++; $display("FAIL %s address got %h want %h", name, address_o, exp_addr);
        end
        address_i = r64()[31:0];
        beat = 0; idx = 0;
        while (beat < 4 && idx < 64) begin
            r = (idx < plen) ? pat[idx] : 1'b1;
            resp_i = r;
            burst_i = r ? bq[beat] : r64();
            @(negedge clk);
            idx++;
            if (r) beat++;
            if (beat < 4) begin
                total++;
                if ({read_o, write_o, resp_o, burst_o} !== {3'b100, 64'h0} ||
                    address_o !== exp_addr) begin
                    bad++;
                    $display("FAIL %s mid-burst beat=%0d r/w/resp got %b addr %h want 100 addr %h",
                             name, beat, {read_o, write_o, resp_o}, address_o, exp_addr);
                end
            end
        end
        resp_i = 1'b0;
        total++;
        if ({read_o, write_o, resp_o} !== 3'b001 || beat != 4) begin
            bad++; $display("FAIL %s done r/w/resp got %b want 001 (beats %0d)", name,
                            {read_o, write_o, resp_o}, beat);
        end
        total++;
        if (line_o !== exp_line) begin
            bad++; $display("FAIL %s line got %h want %h", name, line_o, exp_line);
        end
        last_line = exp_line;
        @(negedge clk);
        read_i = 1'b0; write_i = 1'b0;
        total++;
        if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== exp_line) begin
            bad++; $display("FAIL %s after-done r/w/resp got %b want 000 line %h", name,
                            {read_o, write_o, resp_o}, line_o);
        end
    endtask

    task automatic do_write(input string name, input logic [31:0] addr, input logic [255:0] wl,
                            input logic [15:0] pat, input int plen);
        logic [31:0] exp_addr;
        logic [63:0] exp_beat;
        int          beat;
        int          idx;
        logic        r;
        exp_addr = addr & ~32'h1f;
        write_i = 1'b1; read_i = 1'b0; line_i = wl; address_i = addr; resp_i = 1'b0;
        @(negedge clk);
        total++;
        if ({read_o, write_o, resp_o} !== 3'b010 || address_o !== exp_addr) begin
            bad++; $display("FAIL %s start r/w/resp got %b addr %h want 010 addr %h", name,
                            {read_o, write_o, resp_o}, address_o, exp_addr);
        end
        line_i = r256(); address_i = r64()[31:0];
        beat = 0; idx = 0;
        while (beat < 4 && idx < 64) begin
            exp_beat = wl[beat*64 +: 64];
            total++;
            if (burst_o !== exp_beat || {read_o, write_o, resp_o} !== 3'b010 ||
                address_o !== exp_addr || line_o !== last_line) begin
                bad++;
                $display("FAIL %s beat %0d burst got %h want %h r/w/resp %b", name, beat,
                         burst_o, exp_beat, {read_o, write_o, resp_o});
            end
            r = (idx < plen) ? pat[idx] : 1'b1;
            resp_i = r;
            burst_i = r64();
            @(negedge clk);
            idx++;
            if (r) beat++;
        end
        resp_i = 1'b0;
        total++;
        if ({read_o, write_o, resp_o} !== 3'b001 || burst_o !== 64'h0) begin
            bad++; $display("FAIL %s done r/w/resp got %b burst %h want 001 burst 0", name,
                            {read_o, write_o, resp_o}, burst_o);
        end
        @(negedge clk);
        write_i = 1'b0;
        total++;
        if ({read_o, write_o, resp_o} !== 3'b000 || line_o !== last_line) begin
            bad++; $display("FAIL %s after-done r/w/resp got %b want 000", name,
                            {read_o, write_o, resp_o});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'h0 ||
            line_o !== 256'h0 || burst_o !== 64'h0) begin
            bad++; $display("FAIL reset r/w/resp got %b addr %h burst %h want all zero",
                            {read_o, write_o, resp_o}, address_o, burst_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_line = '0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 6; i++) begin
            resp_i = 1'($urandom);
            burst_i = r64();
            line_i = r256();
            address_i = $urandom;
            @(negedge clk);
            total++;
            if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'h0 ||
                line_o !== 256'h0 || burst_o !== 64'h0) begin
                bad++; $display("FAIL idle cycle %0d r/w/resp got %b addr %h want 000 addr 0", i,
                                {read_o, write_o, resp_o}, address_o);
            end
        end
        resp_i = 1'b0;
    endtask

    task automatic test_read_basic();
        do_read("read_basic", 32'h0000_1234, {8{8'h11}}, {8{8'h22}}, {8{8'h33}}, {8{8'h44}},
                16'h0, 0, 1'b0);
    endtask

    task automatic test_write_basic();
        do_write("write_basic", 32'h0000_0040, r256(), 16'h0, 0);
    endtask

    task automatic test_read_gaps();
        // resp_i sequence 1,0,0,1,1,0,1
        do_read("read_gaps", $urandom, r64(), r64(), r64(), r64(), 16'b0000_0000_0101_1001, 7, 1'b0);
        @(negedge clk);
        do_write("write_gaps", $urandom, r256(), 16'b0000_0000_0011_0010, 6);
    endtask

    task automatic test_both();
        do_read("read_and_write", $urandom, r64(), r64(), r64(), r64(), 16'h0, 0, 1'b1);
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        read_i = 1'b1; address_i = 32'h0000_0ABC;
        @(negedge clk);
        resp_i = 1'b1; burst_i = r64();
        repeat (2) @(negedge clk);
        resp_i = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'h0 || line_o !== 256'h0) begin
            bad++; $display("FAIL reset_mid r/w/resp got %b addr %h want 000 addr 0",
                            {read_o, write_o, resp_o}, address_o);
        end
        read_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_line = '0;
        @(negedge clk);
        do_read("read_after_reset", 32'h0000_0ABC, r64(), r64(), r64(), r64(), 16'h0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        do_write("b2b_write", $urandom, r256(), 16'h0, 0);
        do_read("b2b_read", $urandom, r64(), r64(), r64(), r64(), 16'h0, 0, 1'b0);
        do_write("b2b_write2", $urandom, r256(), 16'h0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 0)
                do_read("rand_read", $urandom, r64(), r64(), r64(), r64(), 16'($urandom),
                        int'($urandom_range(0, 10)), 1'($urandom));
            else
                do_write("rand_write", $urandom, r256(), 16'($urandom),
                         int'($urandom_range(0, 10)));
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_read_basic();
        @(negedge clk);
        test_write_basic();
        @(negedge clk);
        test_read_gaps();
        @(negedge clk);
        test_both();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
